pad_input_scanner: RTL and testbench
====================================

Name: pad_input_scanner

Overview:
- Conditions the single-ended LVCMOS33 input-buffer outputs of the DM interface board (limit switches, fault lines, external triggers).
- Synchronises all pads, then time-shares one debounce evaluator across NUM_CH channels in round-robin order.
- Produces stable levels, sticky rise/fall event flags and a maskable interrupt.
- Sits between the INBUF IO cores and the register/host logic.

Parameters:
- NUM_CH, 8, number of pad channels, 1..32.
- PRESCALE, 100, clk cycles between scan steps, ≥ 3.
- DEBOUNCE, 16, consecutive disagreeing samples needed to flip a level, 1..255.
- CNT_W, 8, per-channel debounce counter width; must satisfy 2^CNT_W > DEBOUNCE.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- pad_y  in  NUM_CH  raw INBUF outputs, asynchronous to clk
- irq_mask  in  NUM_CH  1 = channel may raise irq
- evt_clr  in  NUM_CH  single-cycle pulse per bit; clears both event flags of that channel
- level  out  NUM_CH  debounced stable level
- rise_evt  out  NUM_CH  sticky rising-edge flag
- fall_evt  out  NUM_CH  sticky falling-edge flag
- irq  out  1  registered; OR over channels of (rise_evt|fall_evt) & irq_mask
- scan_idx  out  clog2(NUM_CH)  channel currently being evaluated (debug)

Behaviour:
- Reset: level, rise_evt, fall_evt, irq, all counters, prescaler and scan_idx = 0; FSM = IDLE.
- Sync: each pad_y bit passes through 2 flops (sync[i]) before any use; the synchronisers are also reset to 0.
- Prescaler: counts 0..PRESCALE-1 and wraps. On wrap it emits a one-cycle scan_stb.
- FSM IDLE: waits for scan_stb, then goes to EVAL.
- FSM EVAL (1 cycle): reads cnt[scan_idx] and sync[scan_idx]. Computes agree = (sync == level). Then goes to COMMIT.
- FSM COMMIT (1 cycle), three cases:
  - If agree: cnt <= 0.
  - Else if cnt+1 == DEBOUNCE: level[idx] <= sync; cnt <= 0; set rise_evt (new level 1) or fall_evt (new level 0).
  - Else: cnt <= cnt+1.
  - In all cases scan_idx advances, wrapping NUM_CH-1 -> 0. FSM returns to IDLE.
- Each channel is sampled once per NUM_CH*PRESCALE clocks.
- A clean pad change is reflected on level after exactly DEBOUNCE samples of that channel, plus ≤ 2 sync cycles and ≤ 1 scan period of phase.
- Any agreeing sample resets the count. Glitches shorter than DEBOUNCE-1 consecutive samples never change level.
- Events are sticky until the matching evt_clr bit is pulsed. If set and clear hit the same channel in the same cycle, set wins.
- A rise and a fall on one channel may both be pending; clearing one channel clears both flags.
- irq updates 1 cycle after any flag or mask change.
- irq_mask does not gate the flags themselves, only irq.
- After reset, a pad held high produces level=1 and rise_evt after DEBOUNCE samples. This is intended: host sees the initial state as an event.
- Reset asserted mid-count discards all counts and flags immediately, asynchronously.

Optional Feature:
- Macro: PADSCAN_TIMESTAMP_EN.
- With the macro defined, these are added:
  - a 32-bit free-running ts_cnt (reset 0, wraps);
  - outputs last_evt_ts[31:0] and last_evt_ch[clog2(NUM_CH)-1:0];
  - both outputs are loaded in the COMMIT cycle that sets any event flag;
  - both reset to 0.
- Without the macro, neither the ports nor the counter exist, and behaviour is otherwise identical.

Decomposition:
- Shared package pad_scan_pkg holds:
  - the FSM state enum (IDLE, EVAL, COMMIT);
  - constant SYNC_STAGES = 2;
  - a clog2 helper function.
- Sub-module pad_sync2: a parameterised-width 2-flop synchroniser with async active-high reset, instantiated once with width NUM_CH.
- Prescaler, FSM, counter array and flags stay in the top module.

Test Plan:
Bench parameters: NUM_CH=4, PRESCALE=4, DEBOUNCE=3, so each channel is scanned every 16 clk.
- Reset then idle: all pads 0, run 200 clk -> level=0, no events, irq=0, scan_idx cycles 0,1,2,3.
- Clean rise on ch1: pad_y[1] 0->1 and held -> level[1]=1 and rise_evt[1]=1 within 3*16+16+2 clk. fall_evt stays 0. irq=1 with irq_mask=4'b0010.
- Glitch reject: ch2 pulsed high for 20 clk (≤ 2 samples), then low -> level[2] stays 0 and no event.
- Clear vs set collision: pulse evt_clr[1] in the same cycle rise_evt[1] would set -> flag remains 1. A later evt_clr[1] alone -> flag 0 and irq drops next cycle.
- Mask gating: ch3 fall event with irq_mask[3]=0 -> fall_evt[3]=1 and irq=0. Set irq_mask[3]=1 -> irq=1 one cycle later.
- Reset mid-operation: assert rst while ch0 cnt=2 -> all outputs 0 asynchronously. After release, a held-high ch0 needs the full 3 samples again before level[0]=1.

Source files
------------

// File: rtl/pad_scan_pkg.sv
// rtl/pad_scan_pkg.sv - shared types, constants and helpers for the pad input scanner
package pad_scan_pkg;

  // Scan evaluator states: wait for a strobe, read one channel, write it back.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EVAL   = 2'd1,
    COMMIT = 2'd2
  } scan_state_e;

  // Flop depth of the pad synchroniser.
  localparam int SYNC_STAGES = 2;

  // Bits needed to hold 0..n-1; never less than 1 so single-entry indices stay legal.
  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/pad_sync2.sv
// rtl/pad_sync2.sv - multi-bit flop-chain synchroniser for asynchronous pad inputs
module pad_sync2
  import pad_scan_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [SYNC_STAGES];

  // Shift raw pad bits through the chain; every stage clears on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < SYNC_STAGES; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q_o = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/pad_input_scanner.sv
// rtl/pad_input_scanner.sv - round-robin debounce scanner with sticky edge flags and irq
// Build macro PADSCAN_TIMESTAMP_EN adds last_evt_ts/last_evt_ch event capture.
module pad_input_scanner
  import pad_scan_pkg::*;
#(
  parameter int NUM_CH   = 8,
  parameter int PRESCALE = 100,
  parameter int DEBOUNCE = 16,
  parameter int CNT_W    = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_CH-1:0]         pad_y,
  input  logic [NUM_CH-1:0]         irq_mask,
  input  logic [NUM_CH-1:0]         evt_clr,
  output logic [NUM_CH-1:0]         level,
  output logic [NUM_CH-1:0]         rise_evt,
  output logic [NUM_CH-1:0]         fall_evt,
  output logic                      irq,
  output logic [clog2(NUM_CH)-1:0]  scan_idx
`ifdef PADSCAN_TIMESTAMP_EN
  ,
  output logic [31:0]               last_evt_ts,
  output logic [clog2(NUM_CH)-1:0]  last_evt_ch
`endif
);

  localparam int IDX_W = clog2(NUM_CH);
  localparam int PRE_W = clog2(PRESCALE);

  logic [NUM_CH-1:0] sync;
  logic [PRE_W-1:0]  pre_q;
  logic              scan_stb;
  scan_state_e       state_q, state_d;
  logic              eval_en, commit_en;
  logic [IDX_W-1:0]  scan_idx_q, scan_idx_d;
  logic [CNT_W-1:0]  cnt_q [NUM_CH];
  logic [CNT_W-1:0]  cnt_d [NUM_CH];
  logic [CNT_W-1:0]  cur_cnt_q, cnt_inc;
  logic              smp_q, agree_q;
  logic [NUM_CH-1:0] level_q, level_d, rise_q, rise_d, fall_q, fall_d;
  logic [NUM_CH-1:0] set_rise, set_fall;
  logic              irq_q, irq_d;

  pad_sync2 #(.WIDTH(NUM_CH)) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (pad_y),
    .q_o (sync)
  );

  assign scan_stb = (pre_q == PRE_W'(PRESCALE - 1));
  assign cnt_inc  = cur_cnt_q + CNT_W'(1);

  // Prescaler: free-running 0..PRESCALE-1, strobing once per wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pre_q <= '0;
    else     pre_q <= scan_stb ? '0 : pre_q + PRE_W'(1);
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM next state: one strobe buys exactly one EVAL and one COMMIT cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (scan_stb) state_d = EVAL;
      EVAL:    state_d = COMMIT;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: phase enables for the shared evaluator.
  always_comb begin
    eval_en   = (state_q == EVAL);
    commit_en = (state_q == COMMIT);
  end

  // Evaluator read phase: capture the selected channel's sample, count and agreement.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      smp_q     <= 1'b0;
      agree_q   <= 1'b1;
      cur_cnt_q <= '0;
    end else if (eval_en) begin
      smp_q     <= sync[scan_idx_q];
      agree_q   <= (sync[scan_idx_q] == level_q[scan_idx_q]);
      cur_cnt_q <= cnt_q[scan_idx_q];
    end
  end

  // Evaluator write phase: reset, advance or flip the channel, then move to the next one.
  always_comb begin
    cnt_d      = cnt_q;
    level_d    = level_q;
    set_rise   = '0;
    set_fall   = '0;
    scan_idx_d = scan_idx_q;
    if (commit_en) begin
      scan_idx_d = (scan_idx_q == IDX_W'(NUM_CH - 1)) ? '0 : scan_idx_q + IDX_W'(1);
      if (agree_q) begin
        cnt_d[scan_idx_q] = '0;
      end else if (cnt_inc == CNT_W'(DEBOUNCE)) begin
        cnt_d[scan_idx_q]   = '0;
        level_d[scan_idx_q] = smp_q;
        set_rise[scan_idx_q] = smp_q;
        set_fall[scan_idx_q] = ~smp_q;
      end else begin
        cnt_d[scan_idx_q] = cnt_inc;
      end
    end
  end

  // Sticky flags: a set in the same cycle as a clear wins; irq looks at registered flags.
  always_comb begin
    rise_d = (rise_q & ~evt_clr) | set_rise;
    fall_d = (fall_q & ~evt_clr) | set_fall;
    irq_d  = |((rise_q | fall_q) & irq_mask);
  end

  // Channel state, flags and irq registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= '0;
      level_q    <= '0;
      rise_q     <= '0;
      fall_q     <= '0;
      irq_q      <= 1'b0;
      scan_idx_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= cnt_d[i];
      level_q    <= level_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      irq_q      <= irq_d;
      scan_idx_q <= scan_idx_d;
    end
  end

  assign level    = level_q;
  assign rise_evt = rise_q;
  assign fall_evt = fall_q;
  assign irq      = irq_q;
  assign scan_idx = scan_idx_q;

`ifdef PADSCAN_TIMESTAMP_EN
  logic [31:0]      ts_cnt_q;
  logic [31:0]      last_evt_ts_q;
  logic [IDX_W-1:0] last_evt_ch_q;

  // Free-running timestamp, sampled along with the channel whenever a flip sets a flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ts_cnt_q      <= '0;
      last_evt_ts_q <= '0;
      last_evt_ch_q <= '0;
    end else begin
      ts_cnt_q <= ts_cnt_q + 32'd1;
      if (|(set_rise | set_fall)) begin
        last_evt_ts_q <= ts_cnt_q;
        last_evt_ch_q <= scan_idx_q;
      end
    end
  end

  assign last_evt_ts = last_evt_ts_q;
  assign last_evt_ch = last_evt_ch_q;
`endif

endmodule

// File: tb/tb_pad_input_scanner.sv
// tb/tb_pad_input_scanner.sv - scoreboard bench for pad_input_scanner with a per-sample reference model
module tb_pad_input_scanner;
  localparam int NCH = 4;
  localparam int PRE = 4;
  localparam int DEB = 3;

  logic           clk;
  logic           rst;
  logic [NCH-1:0] pad_y, irq_mask, evt_clr;
  logic [NCH-1:0] level, rise_evt, fall_evt;
  logic           irq;
  logic [1:0]     scan_idx;

  pad_input_scanner #(.NUM_CH(NCH), .PRESCALE(PRE), .DEBOUNCE(DEB), .CNT_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .pad_y    (pad_y),
    .irq_mask (irq_mask),
    .evt_clr  (evt_clr),
    .level    (level),
    .rise_evt (rise_evt),
    .fall_evt (fall_evt),
    .irq      (irq),
    .scan_idx (scan_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]     idx;
    logic [NCH-1:0] lvl;
    logic [NCH-1:0] rise;
    logic [NCH-1:0] fall;
  } exp_t;

  exp_t exp_q[$];
  logic irq_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 0;

  // Reference model: one entry of state per channel, updated once per sample of it.
  logic [NCH-1:0] m_lvl, m_rise, m_fall, cur_pads;
  int             m_run [NCH];
  int             m_idx;
  bit             prev_valid;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, expv, $time);
    end
  endtask

  task automatic model_reset();
    m_lvl = '0; m_rise = '0; m_fall = '0; m_idx = 0; prev_valid = 0;
    for (int i = 0; i < NCH; i++) m_run[i] = 0;
  endtask

  // One scan period. Pads/mask/clr_a change just after the previous commit; clr_b is
  // asserted across this period's commit edge (collision with a set when coll=1).
  task automatic step(input logic [NCH-1:0] pads, input logic [NCH-1:0] mask,
                      input logic [NCH-1:0] clr_a, input bit coll);
    exp_t e;
    logic [NCH-1:0] setv, clr_b;
    int ch;
    m_rise &= ~clr_a;
    m_fall &= ~clr_a;
    if (prev_valid) irq_q.push_back(|((m_rise | m_fall) & mask));
    prev_valid = 1;
    ch   = m_idx;
    setv = '0;
    if (pads[ch] == m_lvl[ch]) m_run[ch] = 0;
    else begin
      m_run[ch]++;
      if (m_run[ch] == DEB) begin
        m_lvl[ch] = pads[ch];
        m_run[ch] = 0;
        setv[ch]  = 1'b1;
      end
    end
    clr_b  = coll ? setv : '0;
    m_rise = (m_rise & ~clr_b) | (setv & m_lvl);
    m_fall = (m_fall & ~clr_b) | (setv & ~m_lvl);
    m_idx  = (m_idx + 1) % NCH;
    e.idx = 2'(m_idx); e.lvl = m_lvl; e.rise = m_rise; e.fall = m_fall;
    exp_q.push_back(e);
    cur_pads = pads;
    pad_y = pads; irq_mask = mask; evt_clr = clr_a;
    @(posedge clk); #1 evt_clr = '0;
    @(posedge clk); @(posedge clk); #1 evt_clr = clr_b;
    @(posedge clk); #1 evt_clr = '0;
  endtask

  task automatic run(input int n, input logic [NCH-1:0] pads, input logic [NCH-1:0] mask,
                     input logic [NCH-1:0] clr_first, input bit coll);
    for (int i = 0; i < n; i++) step(pads, mask, (i == 0) ? clr_first : '0, coll);
  endtask

  // Last irq expectation for the final commit, then park the monitor.
  task automatic drain();
    irq_q.push_back(|((m_rise | m_fall) & irq_mask));
    @(posedge clk); @(posedge clk); #1;
    @(negedge clk) mon_en = 0;
  endtask

  task automatic release_reset();
    model_reset();
    @(negedge clk) begin rst = 1'b0; mon_en = 1; end
    @(posedge clk); @(posedge clk); #1;
  endtask

  // Monitor: each scan_idx move marks a commit; compare it, then irq two cycles later.
  initial begin
    int idle;
    logic [1:0] prev;
    exp_t e;
    logic ei;
    idle = 0;
    prev = '0;
    forever begin
      @(posedge clk); #1;
      if (!mon_en) begin idle = 0; prev = '0; continue; end
      if (scan_idx != prev) begin
        prev = scan_idx;
        idle = 0;
        if (exp_q.size() == 0) check("commit_unexpected", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("scan_idx", 32'(scan_idx), 32'(e.idx));
          check("level", 32'(level), 32'(e.lvl));
          check("rise_evt", 32'(rise_evt), 32'(e.rise));
          check("fall_evt", 32'(fall_evt), 32'(e.fall));
        end
        @(posedge clk); @(posedge clk); #1;
        if (irq_q.size() == 0) check("irq_unexpected", 1, 0);
        else begin
          ei = irq_q.pop_front();
          check("irq", 32'(irq), 32'(ei));
        end
      end else begin
        idle++;
        if (idle > 40) begin
          check("commit_timeout", 0, 1);
          idle = 0;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NCH-1:0] rp, rm, rc;
    rst = 1'b1; pad_y = '0; irq_mask = '0; evt_clr = '0; cur_pads = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_level", 32'(level), 0);
    check("rst_rise", 32'(rise_evt), 0);
    check("rst_fall", 32'(fall_evt), 0);
    check("rst_irq", 32'(irq), 0);
    check("rst_scan_idx", 32'(scan_idx), 0);
    release_reset();

    // Idle: pads low for 200 clk.
    run(50, 4'b0000, 4'b0000, 4'b0000, 0);
    // Clean rise on ch1, irq enabled for ch1.
    run(20, 4'b0010, 4'b0010, 4'b0000, 0);
    // Glitch on ch2 for 20 clk, then low.
    run(5, 4'b0110, 4'b0010, 4'b0000, 0);
    run(12, 4'b0010, 4'b0010, 4'b0000, 0);
    // Fall on ch1, then a rise whose set collides with a clear, then a lone clear.
    run(16, 4'b0000, 4'b0010, 4'b1111, 0);
    run(16, 4'b0010, 4'b0010, 4'b1111, 1);
    run(8, 4'b0010, 4'b0010, 4'b0010, 0);
    // Mask gating on ch3.
    run(16, 4'b1010, 4'b0000, 4'b1111, 0);
    run(16, 4'b0010, 4'b0000, 4'b1000, 0);
    run(4, 4'b0010, 4'b1000, 4'b0000, 0);
    // Random traffic: slowly wandering pads, random masks and clears.
    rp = cur_pads;
    for (int i = 0; i < 150; i++) begin
      for (int b = 0; b < NCH; b++) if ($urandom_range(0, 5) == 0) rp[b] = ~rp[b];
      rm = NCH'($urandom);
      rc = ($urandom_range(0, 3) == 0) ? NCH'($urandom) : '0;
      step(rp, rm, rc, ($urandom_range(0, 3) == 0));
    end
    // Reset while ch0 is two samples into a rise.
    run(16, 4'b1110, 4'b1111, 4'b0000, 0);
    for (int i = 0; i < 20; i++) begin
      step(4'b1111, 4'b1111, 4'b0000, 0);
      if (m_run[0] == 2) break;
    end
    check("pre_reset_ch0_count", 32'(m_run[0]), 2);
    drain();
    @(negedge clk) rst = 1'b1;
    #1;
    check("mid_rst_level", 32'(level), 0);
    check("mid_rst_rise", 32'(rise_evt), 0);
    check("mid_rst_fall", 32'(fall_evt), 0);
    check("mid_rst_irq", 32'(irq), 0);
    check("mid_rst_scan_idx", 32'(scan_idx), 0);
    repeat (2) @(posedge clk);
    release_reset();
    run(16, 4'b1111, 4'b1111, 4'b0000, 0);
    drain();
    repeat (4) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
